// File: rtl/i2c_master.sv
// Single-master I2C controller: START, {addr,rw}, 0..16 data bytes, STOP.
// SCL is push-pull; SDA is open-drain (pulled low or released).
module i2c_master #(
    parameter int unsigned QUARTER = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [6:0]   addr,
    input  logic [127:0] data,
    input  logic [4:0]   packets,
    input  logic         rw,
    input  logic         start,
    output logic         ready,
    output logic [127:0] read_data,
    output logic         nack,
    output logic         scl,
    inout  wire          sda
);

    localparam int unsigned CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP, S_DONE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     q, q_n;
    logic [2:0]     bit_idx, bit_n;
    logic [4:0]     byte_idx, idx_n;
    logic [6:0]     addr_r;
    logic [127:0]   data_r;
    logic [4:0]     pkts_r;
    logic           rw_r;
    logic [7:0]     shift_r, shift_n;
    logic           sda_low;
    logic           scl_n, low_n;
    logic           latch, set_nack, store;
    logic           tick, end_bit, sample, sda_bit;
    logic [7:0]     addr_byte;
    logic [4:0]     pkts_clamped;

    assign sda          = sda_low ? 1'b0 : 1'bz;
    assign tick         = (cnt == CW'(QUARTER - 1));
    assign end_bit      = tick && (q == 2'd3);
    assign sample       = tick && (q == 2'd2);
    assign addr_byte    = {addr_r, rw_r};
    assign pkts_clamped = (packets > 5'd16) ? 5'd16 : packets;

    // Anything but a clean 1 on the line reads as 0 (ACK / data 0).
    always_comb begin
        sda_bit = 1'b0;
        if (sda == 1'b1) sda_bit = 1'b1;
    end

    // Next state, phase counters and bit/byte bookkeeping.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        q_n      = q;
        bit_n    = bit_idx;
        idx_n    = byte_idx;
        shift_n  = shift_r;
        latch    = 1'b0;
        set_nack = 1'b0;
        store    = 1'b0;

        if (state != S_IDLE && state != S_DONE) begin
            cnt_n = tick ? '0 : cnt + CW'(1);
            if (tick) q_n = q + 2'd1;
        end

        case (state)
            S_IDLE: begin
                if (start && ready) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    q_n     = '0;
                    latch   = 1'b1;
                end
            end
            S_START: begin
                if (end_bit) begin
                    state_n = S_ADDR;
                    bit_n   = 3'd7;
                end
            end
            S_ADDR: begin
                if (end_bit) begin
                    if (bit_idx == 3'd0) state_n = S_ADDR_ACK;
                    else                 bit_n   = bit_idx - 3'd1;
                end
            end
            S_ADDR_ACK: begin
                if (sample && sda_bit) set_nack = 1'b1;
                if (end_bit) begin
                    bit_n   = 3'd7;
                    idx_n   = 5'd0;
                    state_n = (pkts_r == 5'd0) ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) shift_n = {shift_r[6:0], sda_bit};
                if (end_bit) begin
                    if (bit_idx == 3'd0) begin
                        state_n = S_DATA_ACK;
                        store   = rw_r;
                    end else begin
                        bit_n = bit_idx - 3'd1;
                    end
                end
            end
            S_DATA_ACK: begin
                if (!rw_r && sample && sda_bit) set_nack = 1'b1;
                if (end_bit) begin
                    idx_n   = byte_idx + 5'd1;
                    bit_n   = 3'd7;
                    state_n = (byte_idx + 5'd1 == pkts_r) ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (end_bit) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                q_n     = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line levels for the upcoming cycle, decoded from next-state values so the pins are registered.
    always_comb begin
        scl_n = 1'b1;
        low_n = 1'b0;
        case (state_n)
            S_START: begin
                scl_n = (q_n != 2'd3);
                low_n = q_n[1];
            end
            S_ADDR: begin
                scl_n = q_n[1];
                low_n = !addr_byte[bit_n];
            end
            S_ADDR_ACK: scl_n = q_n[1];
            S_DATA: begin
                scl_n = q_n[1];
                low_n = !rw_r && !data_r[{idx_n[3:0], bit_n}];
            end
            S_DATA_ACK: begin
                scl_n = q_n[1];
                low_n = rw_r && (idx_n != pkts_r - 5'd1);
            end
            S_STOP: begin
                scl_n = q_n[1];
                low_n = (q_n != 2'd3);
            end
            default: begin
                scl_n = 1'b1;
                low_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            q         <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_r   <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            pkts_r    <= '0;
            rw_r      <= 1'b0;
            ready     <= 1'b1;
            scl       <= 1'b1;
            sda_low   <= 1'b0;
            read_data <= '0;
            nack      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            q        <= q_n;
            bit_idx  <= bit_n;
            byte_idx <= idx_n;
            shift_r  <= shift_n;
            ready    <= (state_n == S_IDLE);
            scl      <= scl_n;
            sda_low  <= low_n;
            if (latch) begin
                addr_r <= addr;
                data_r <= data;
                pkts_r <= pkts_clamped;
                rw_r   <= rw;
                nack   <= 1'b0;
            end
            if (set_nack) nack <= 1'b1;
            if (store) read_data[{byte_idx[3:0], 3'b000} +: 8] <= shift_r;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a slave model drives ACK/read bits, a bus monitor decodes
// 9-bit frames and a completion monitor checks timing, nack and read_data.
module tb_i2c_master;

    localparam int unsigned QUARTER  = 2;
    localparam int unsigned BIT_CLKS = 4 * QUARTER;

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   addr;
    logic [127:0] data;
    logic [4:0]   packets;
    logic         rw;
    logic         start;
    logic         ready;
    logic [127:0] read_data;
    logic         nack;
    logic         scl;
    wire          sda;
    logic         slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master #(.QUARTER(QUARTER)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .packets(packets),
        .rw(rw), .start(start), .ready(ready), .read_data(read_data),
        .nack(nack), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  cycles;
        logic         nack;
        logic [127:0] rdata;
        int unsigned  frames;
    } done_exp_t;

    logic [8:0] frame_q[$];
    done_exp_t  done_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Slave configuration for the current transaction.
    bit         slave_ack   = 1'b1;
    bit         slave_read  = 1'b0;
    int         slave_nbytes = 0;
    logic [7:0] slave_rd [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic slave_drive(input int s);
        int f;
        int b;
        if (s < 0) return 1'b0;
        f = s / 9;
        b = s % 9;
        if (f == 0) return (b == 8) && slave_ack;
        if (f - 1 >= slave_nbytes) return 1'b0;
        if (slave_read) return (b < 8) && !slave_rd[f-1][7-b];
        return (b == 8) && slave_ack;
    endfunction

    // Slave: restart slot count on START, update its drive on every SCL fall.
    int   slot = -1;
    logic s_prev_scl = 1'b1;
    logic s_prev_sda = 1'b1;
    always @(negedge clk) begin
        logic cs;
        logic ds;
        cs = scl;
        ds = sda;
        if (s_prev_scl && cs && s_prev_sda && !ds) begin
            slot      = -1;
            slave_low = 1'b0;
        end else if (s_prev_scl && !cs) begin
            slot++;
            slave_low = slave_drive(slot);
        end
        s_prev_scl = cs;
        s_prev_sda = ds;
    end

    // Bus monitor: collect 9 bits per frame on SCL rises, compare with the scoreboard.
    logic [8:0] shreg = '0;
    int         nbits = 0;
    int         frames_seen = 0;
    logic       m_prev_scl = 1'b1;
    logic       m_prev_sda = 1'b1;
    always @(negedge clk) begin
        logic       cs;
        logic       ds;
        logic [8:0] e;
        cs = scl;
        ds = sda;
        if (m_prev_scl && cs && m_prev_sda && !ds) begin
            nbits       = 0;
            frames_seen = 0;
        end else if (!m_prev_scl && cs) begin
            shreg = {shreg[7:0], ds};
            nbits++;
            if (nbits == 9) begin
                nbits = 0;
                frames_seen++;
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame: unexpected frame %h, none expected", shreg);
                end else begin
                    e = frame_q.pop_front();
                    check("frame", 128'(shreg), 128'(e));
                end
            end
        end
        m_prev_scl = cs;
        m_prev_sda = ds;
    end

    // Completion monitor: on ready rising, check busy length, nack, read_data, frame count.
    int unsigned busy_cycles  = 0;
    logic        d_prev_ready = 1'b1;
    always @(negedge clk) begin
        done_exp_t e;
        if (reset) begin
            busy_cycles  = 0;
            d_prev_ready = 1'b1;
        end else begin
            if (!ready) begin
                busy_cycles++;
            end else if (!d_prev_ready) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done: unexpected completion after %0d cycles", busy_cycles);
                end else begin
                    e = done_q.pop_front();
                    check("busy_cycles", 128'(busy_cycles), 128'(e.cycles));
                    check("nack", 128'(nack), 128'(e.nack));
                    check("read_data", read_data, e.rdata);
                    check("frame_count", 128'(frames_seen), 128'(e.frames));
                end
                busy_cycles = 0;
            end
            d_prev_ready = ready;
        end
    end

    // Called at a negedge; pushes expectations (if any) and pulses start for one cycle.
    task automatic issue(input logic [6:0] a, input logic r, input logic [4:0] p,
                         input logic [127:0] d, input bit ack, input logic [7:0] exp_addr,
                         input bit exp_nack, input logic [127:0] exp_rdata, input bit expect_done);
        int        pe;
        done_exp_t de;
        pe = (p > 5'd16) ? 16 : int'(p);
        slave_ack    = ack;
        slave_read   = r;
        slave_nbytes = pe;
        if (expect_done) begin
            frame_q.push_back({exp_addr, ~ack});
            for (int i = 0; i < pe; i++) begin
                if (r) frame_q.push_back({slave_rd[i], (i == pe - 1)});
                else   frame_q.push_back({d[i*8 +: 8], ~ack});
            end
            de.cycles = (11 + 9 * pe) * BIT_CLKS + 1;
            de.nack   = exp_nack;
            de.rdata  = exp_rdata;
            de.frames = 1 + pe;
            done_q.push_back(de);
        end
        addr    = a;
        rw      = r;
        packets = p;
        data    = d;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_fall", 128'(ready), 128'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: ready still %0b after %0d cycles", ready, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        addr    = '0;
        data    = '0;
        packets = '0;
        rw      = 1'b0;
        slave_rd[0] = 8'h11;
        slave_rd[1] = 8'h22;
        slave_rd[2] = 8'h33;
        slave_rd[3] = 8'h44;
        for (int i = 4; i < 16; i++) slave_rd[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_scl", 128'(scl), 128'(1));
        check("rst_sda", 128'(sda), 128'(1));
        check("rst_nack", 128'(nack), 128'(0));
        check("rst_read_data", read_data, 128'(0));

        // Write two bytes, slave ACKs.
        issue(7'h21, 1'b0, 5'd2, 128'hA0F0, 1'b1, 8'h42, 1'b0, 128'h0, 1'b1);
        wait_idle();
        // Back-to-back write, no slave ACK.
        issue(7'h21, 1'b0, 5'd2, 128'hFFAA, 1'b0, 8'h42, 1'b1, 128'h0, 1'b1);
        wait_idle();
        // Read four bytes.
        issue(7'h21, 1'b1, 5'd4, 128'h0, 1'b1, 8'h43, 1'b0, 128'h44332211, 1'b1);
        wait_idle();

        // Write with a start pulse while busy in DATA that must be ignored.
        issue(7'h5A, 1'b0, 5'd3, 128'h123456, 1'b1, 8'hB4, 1'b0, 128'h44332211, 1'b1);
        repeat (11 * BIT_CLKS) @(negedge clk);
        addr    = 7'h01;
        rw      = 1'b1;
        packets = 5'd1;
        data    = '1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 128'(ready), 128'(0));
        wait_idle();

        // Reset in the middle of ADDR, then a full transaction.
        @(negedge clk);
        issue(7'h7F, 1'b0, 5'd1, 128'h77, 1'b1, 8'hFE, 1'b0, 128'h0, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 128'(ready), 128'(1));
        check("abort_scl", 128'(scl), 128'(1));
        check("abort_sda", 128'(sda), 128'(1));
        check("abort_read_data", read_data, 128'(0));
        reset = 1'b0;
        @(negedge clk);
        issue(7'h3C, 1'b0, 5'd1, 128'h5B, 1'b1, 8'h78, 1'b0, 128'h0, 1'b1);
        wait_idle();

        // Zero data bytes.
        issue(7'h10, 1'b0, 5'd0, 128'h0, 1'b1, 8'h20, 1'b0, 128'h0, 1'b1);
        wait_idle();

        // packets above 16 clamps to 16 bytes.
        issue(7'h7F, 1'b0, 5'd20, 128'hFFEEDDCCBBAA99887766554433221100, 1'b1, 8'hFE,
              1'b0, 128'h0, 1'b1);
        wait_idle();

        repeat (4) @(negedge clk);
        check("frames_left", 128'(frame_q.size()), 128'(0));
        check("dones_left", 128'(done_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
